l15_data_refill_ctrl: RTL and testbench
=======================================

L15_DATA_REFILL_CTRL -- requirements
Module: l15_data_refill_ctrl

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 128, giving the data-RAM line width in bits.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 7, giving the data-RAM address width.
REQ-003 The module SHALL have parameter BEAT_WIDTH, default 32, giving the refill beat width; NBEATS = DATA_WIDTH/BEAT_WIDTH, a power of 2 and at least 2.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port rst, input, 1, the reset, which is synchronous and active-high.
REQ-006 The module SHALL have ports refill_req_valid (in, 1), refill_req_ready (out, 1) and refill_req_addr (in, ADDR_WIDTH): the line-address handshake.
REQ-007 The module SHALL have ports beat_valid (in, 1), beat_ready (out, 1), beat_data (in, BEAT_WIDTH) and beat_last (in, 1): the refill beat stream, lowest beat first.
REQ-008 The module SHALL have ports rd_req (in, 1), rd_addr (in, ADDR_WIDTH) and rd_gnt (out, 1): the lookup read request.
REQ-009 The module SHALL have ports rd_rvalid (out, 1) and rd_rdata (out, DATA_WIDTH): the read response.
REQ-010 The module SHALL have ports ram_req (out, 1), ram_write (out, 1), ram_addr (out, ADDR_WIDTH), ram_wdata (out, DATA_WIDTH) and ram_be (out, DATA_WIDTH/8): the data-RAM port.
REQ-011 The module SHALL have port ram_rdata (in, DATA_WIDTH): RAM read data, valid one cycle after a read request.
REQ-012 The module SHALL have ports refill_done (out, 1), a one-cycle pulse when a line is written, and refill_err (out, 1), a sticky beat-count error flag.

Function
REQ-013 The FSM SHALL have three states, IDLE, COLLECT and WRITE; refill_req_ready=1 only in IDLE.
REQ-014 In IDLE, refill_req_valid&ready SHALL latch refill_req_addr, clear the beat counter and go to COLLECT.
REQ-015 In COLLECT, beat_ready=1; each beat_valid&beat_ready SHALL store beat_data into slice [cnt*BEAT_WIDTH +: BEAT_WIDTH] of the line buffer and increment cnt (log2(NBEATS) bits).
REQ-016 Beat acceptance with cnt==NBEATS-1 SHALL move to WRITE, regardless of beat_last.
REQ-017 If beat_last=1 on an accepted beat with cnt!=NBEATS-1, or beat_last=0 on the beat with cnt==NBEATS-1, refill_err SHALL set and stay set until reset; the line is still completed on the NBEATS-th beat and an early last does not end collection.
REQ-018 beat_ready SHALL be 0 outside COLLECT.
REQ-019 In WRITE, the module SHALL drive ram_req=1, ram_write=1, ram_addr=latched address, ram_wdata=line buffer and ram_be=all ones for exactly one cycle, pulse refill_done in the same cycle, then return to IDLE.
REQ-020 Write has priority: in WRITE, rd_gnt=0 and a pending rd_req SHALL stall with no loss; in IDLE and COLLECT, rd_gnt=rd_req.
REQ-021 On a granted read, the module SHALL drive ram_req=1, ram_write=0, ram_addr=rd_addr, ram_be=0 in the same cycle, combinationally.
REQ-022 rd_rvalid SHALL be 1 exactly one cycle after each rd_gnt, with rd_rdata=ram_rdata in that cycle; back-to-back grants SHALL give back-to-back responses.
REQ-023 When neither a write nor a grant is active, ram_req and ram_write SHALL be 0, and ram_addr/ram_wdata/ram_be are don't-care but driven to 0.
REQ-024 A read of the address under refill before WRITE SHALL return the old RAM content; no forwarding.
REQ-025 Beat and read traffic in the same COLLECT cycle SHALL both be serviced; throughput in COLLECT is one beat per cycle.

Reset
REQ-026 While rst=1, the module SHALL set state=IDLE, cnt=0, refill_err=0 and rd_rvalid=0, and drive refill_done=0, ram_req=0 and ram_write=0.
REQ-027 While rst=1, refill_req_ready=0, beat_ready=0 and rd_gnt=0; the line buffer need not reset.
REQ-028 Reset asserted mid-COLLECT or in WRITE SHALL abandon the refill with no RAM write, and a response pending from a grant in the prior cycle SHALL be dropped.

Verification
REQ-029 Refill addr=0x05 with beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 (last on the 4th) -> one RAM write to 0x05 with data 0x44444444_33333333_22222222_11111111, be=0xFFFF, refill_done pulse, refill_err=0.
REQ-030 rd_req held with rd_addr=0x05 through the WRITE cycle -> rd_gnt=0 in WRITE, granted the next cycle, rd_rvalid one cycle later with the new line.
REQ-031 Beats delivered with gaps of 0-3 idle cycles -> identical RAM write; beat_ready drops in WRITE.
REQ-032 beat_last on the 2nd beat -> refill_err=1 and stays 1; the write occurs after the 4th beat.
REQ-033 rst pulsed after 2 beats -> no RAM write, IDLE, refill_req_ready=1 next cycle; a new refill completes normally.
REQ-034 Read to 0x05 during COLLECT of a refill to 0x05 -> old data returned; 4 consecutive reads -> 4 consecutive rd_rvalid cycles.

Source files
------------

// File: rtl/l15_data_refill_ctrl.sv
// L1.5 data-RAM refill controller: collects refill beats into a line buffer and writes the
// full line in one cycle, while servicing lookup reads on the shared RAM port.
module l15_data_refill_ctrl #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned BEAT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      refill_req_valid,
    output logic                      refill_req_ready,
    input  logic [ADDR_WIDTH-1:0]     refill_req_addr,
    input  logic                      beat_valid,
    output logic                      beat_ready,
    input  logic [BEAT_WIDTH-1:0]     beat_data,
    input  logic                      beat_last,
    input  logic                      rd_req,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic                      rd_gnt,
    output logic                      rd_rvalid,
    output logic [DATA_WIDTH-1:0]     rd_rdata,
    output logic                      ram_req,
    output logic                      ram_write,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    output logic [DATA_WIDTH/8-1:0]   ram_be,
    input  logic [DATA_WIDTH-1:0]     ram_rdata,
    output logic                      refill_done,
    output logic                      refill_err
);
    localparam int unsigned NBEATS = DATA_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W  = $clog2(NBEATS);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBEATS - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] line_q, line_d;
    logic                  err_q, err_d;
    logic                  rd_rvalid_q, rd_rvalid_d;

    // Next-state and port logic; every output forced inactive while rst is high.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        addr_d           = addr_q;
        line_d           = line_q;
        err_d            = err_q;
        refill_req_ready = 1'b0;
        beat_ready       = 1'b0;
        rd_gnt           = 1'b0;
        refill_done      = 1'b0;
        ram_req          = 1'b0;
        ram_write        = 1'b0;
        ram_addr         = '0;
        ram_wdata        = '0;
        ram_be           = '0;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    refill_req_ready = 1'b1;
                    if (refill_req_valid) begin
                        addr_d  = refill_req_addr;
                        cnt_d   = '0;
                        state_d = COLLECT;
                    end
                end
                COLLECT: begin
                    beat_ready = 1'b1;
                    if (beat_valid) begin
                        for (int i = 0; i < NBEATS; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                line_d[i*BEAT_WIDTH +: BEAT_WIDTH] = beat_data;
                            end
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                        // beat_last must coincide exactly with the final beat
                        if ((cnt_q == CNT_LAST) != beat_last) begin
                            err_d = 1'b1;
                        end
                        if (cnt_q == CNT_LAST) begin
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    refill_done = 1'b1;
                    ram_req     = 1'b1;
                    ram_write   = 1'b1;
                    ram_addr    = addr_q;
                    ram_wdata   = line_q;
                    ram_be      = '1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // Reads stall only behind the line write
            if (state_q != WRITE && rd_req) begin
                rd_gnt   = 1'b1;
                ram_req  = 1'b1;
                ram_addr = rd_addr;
            end
        end

        rd_rvalid_d = rd_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rd_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rd_rvalid_q <= rd_rvalid_d;
        end
    end

    // Line buffer and latched address need no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        line_q <= line_d;
    end

    // Gating by rst drops a response due from a grant in the cycle before reset.
    assign rd_rvalid  = rd_rvalid_q & ~rst;
    assign refill_err = err_q & ~rst;
    assign rd_rdata   = ram_rdata;

endmodule

// File: tb/tb_l15_data_refill_ctrl.sv
// Randomized bench for l15_data_refill_ctrl: a transaction-level model predicts every port,
// and a behavioural RAM answers the DUT's RAM port.
module tb_l15_data_refill_ctrl;
    localparam int unsigned DW = 128;
    localparam int unsigned AW = 7;
    localparam int unsigned BW = 32;
    localparam int unsigned NB = DW / BW;
    localparam int unsigned DEPTH = 2 ** AW;

    logic            clk = 1'b0;
    logic            rst;
    logic            refill_req_valid, refill_req_ready;
    logic [AW-1:0]   refill_req_addr;
    logic            beat_valid, beat_ready, beat_last;
    logic [BW-1:0]   beat_data;
    logic            rd_req, rd_gnt, rd_rvalid;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_rdata;
    logic            ram_req, ram_write;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata, ram_rdata;
    logic [DW/8-1:0] ram_be;
    logic            refill_done, refill_err;

    l15_data_refill_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BEAT_WIDTH(BW)) dut (
        .clk(clk), .rst(rst),
        .refill_req_valid(refill_req_valid), .refill_req_ready(refill_req_ready),
        .refill_req_addr(refill_req_addr),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
        .beat_last(beat_last),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
        .ram_req(ram_req), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata),
        .refill_done(refill_done), .refill_err(refill_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_line(input int unsigned i);
        logic [31:0] w;
        w = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
        return {w, ~w, w ^ 32'h0000_FFFF, w + 32'd1};
    endfunction

    // Behavioural data RAM: one-cycle read latency, byte enables assumed full on writes.
    logic [DW-1:0] env_mem [DEPTH];
    logic          mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) env_mem[i] <= init_line(i);
        end else if (ram_req && ram_write) begin
            env_mem[ram_addr] <= ram_wdata;
        end
        if (ram_req && !ram_write) ram_rdata <= env_mem[ram_addr];
    end

    // Reference model state (transaction level)
    logic          m_collect, m_write, m_err, m_pend;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_beats[$];
    logic [DW-1:0] m_line, m_pend_data;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [BW-1:0] dir_beats [NB];
    int            exp_writes, obs_writes;
    int            n_checks, n_pass;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        check(tag, DW'(got), DW'(exp));
    endtask

    // Check all outputs at the falling edge, then advance the model past the rising edge.
    task automatic tick();
        logic gnt_e;
        @(negedge clk);
        if (rst) begin
            check1("rst_req_ready", refill_req_ready, 1'b0);
            check1("rst_beat_ready", beat_ready, 1'b0);
            check1("rst_rd_gnt", rd_gnt, 1'b0);
            check1("rst_ram_req", ram_req, 1'b0);
            check1("rst_ram_write", ram_write, 1'b0);
            check1("rst_refill_done", refill_done, 1'b0);
            check1("rst_rd_rvalid", rd_rvalid, 1'b0);
            check1("rst_refill_err", refill_err, 1'b0);
            m_collect = 1'b0;
            m_write   = 1'b0;
            m_err     = 1'b0;
            m_pend    = 1'b0;
        end else begin
            gnt_e = rd_req && !m_write;
            check1("req_ready", refill_req_ready, !m_collect && !m_write);
            check1("beat_ready", beat_ready, m_collect);
            check1("rd_gnt", rd_gnt, gnt_e);
            check1("refill_done", refill_done, m_write);
            check1("ram_req", ram_req, m_write || gnt_e);
            check1("ram_write", ram_write, m_write);
            check1("refill_err", refill_err, m_err);
            check1("rd_rvalid", rd_rvalid, m_pend);
            if (m_pend) check("rd_rdata", rd_rdata, m_pend_data);
            if (m_write) begin
                check("wr_addr", DW'(ram_addr), DW'(m_addr));
                check("wr_data", ram_wdata, m_line);
                check("wr_be", DW'(ram_be), DW'(16'hFFFF));
            end else if (gnt_e) begin
                check("rd_ram_addr", DW'(ram_addr), DW'(rd_addr));
                check("rd_ram_be", DW'(ram_be), '0);
            end else begin
                check("idle_ram_addr", DW'(ram_addr), '0);
                check("idle_ram_wdata", ram_wdata, '0);
                check("idle_ram_be", DW'(ram_be), '0);
            end
            if (ram_req && ram_write) obs_writes++;

            m_pend = gnt_e;
            if (gnt_e) m_pend_data = ref_mem[rd_addr];
            if (m_write) begin
                ref_mem[m_addr] = m_line;
                exp_writes++;
                m_write = 1'b0;
            end else if (!m_collect) begin
                if (refill_req_valid) begin
                    m_collect = 1'b1;
                    m_addr    = refill_req_addr;
                    m_beats.delete();
                end
            end else if (beat_valid) begin
                if (beat_last != (m_beats.size() == NB - 1)) m_err = 1'b1;
                m_beats.push_back(beat_data);
                if (m_beats.size() == NB) begin
                    for (int i = 0; i < NB; i++) m_line[i*BW +: BW] = m_beats[i];
                    m_collect = 1'b0;
                    m_write   = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rd(input int unsigned rd_prob, input bit rd_fix);
        rd_req  = ($urandom_range(99, 0) < rd_prob);
        rd_addr = rd_fix ? 7'h05 : AW'($urandom);
    endtask

    task automatic run_refill(input logic [AW-1:0] addr, input bit use_dir, input int unsigned max_gap,
                              input int last_at, input int rst_after,
                              input int unsigned rd_prob, input bit rd_fix);
        int guard;
        refill_req_valid = 1'b1;
        refill_req_addr  = addr;
        guard = 0;
        do begin
            drive_rd(rd_prob, rd_fix);
            tick();
            guard++;
        end while (!m_collect && guard < 20);
        refill_req_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            beat_valid = 1'b0;
            repeat ($urandom_range(max_gap, 0)) begin
                drive_rd(rd_prob, rd_fix);
                tick();
            end
            beat_valid = 1'b1;
            beat_data  = use_dir ? dir_beats[i] : $urandom;
            beat_last  = (i == last_at);
            drive_rd(rd_prob, rd_fix);
            tick();
            beat_valid = 1'b0;
            beat_last  = 1'b0;
            if (rst_after == i + 1) begin
                rst = 1'b1;
                drive_rd(rd_prob, rd_fix);
                tick();
                rst = 1'b0;
                return;
            end
        end
        repeat (2) begin
            drive_rd(rd_prob, rd_fix);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        refill_req_valid = 1'b0; refill_req_addr = '0;
        beat_valid = 1'b0; beat_data = '0; beat_last = 1'b0;
        rd_req = 1'b0; rd_addr = '0;
        m_collect = 1'b0; m_write = 1'b0; m_err = 1'b0; m_pend = 1'b0;
        m_addr = '0; m_line = '0; m_pend_data = '0;
        exp_writes = 0; obs_writes = 0; n_checks = 0; n_pass = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_line(i);
        @(posedge clk);
        #1;
        mem_init = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Known-pattern refill with a read of the same line held throughout
        dir_beats = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        run_refill(7'h05, 1'b1, 0, NB - 1, 0, 100, 1'b1);
        check("mem5_line", env_mem[5], 128'h44444444_33333333_22222222_11111111);

        // Same line with 0-3 cycle gaps between beats
        dir_beats = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};
        run_refill(7'h05, 1'b1, 3, NB - 1, 0, 100, 1'b1);
        check("mem5_gaps", env_mem[5], 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000);

        // Early beat_last raises a sticky error; later refills keep it
        run_refill(7'h09, 1'b0, 1, 1, 0, 30, 1'b0);
        run_refill(7'h0A, 1'b0, 2, NB - 1, 0, 30, 1'b0);

        // Reset after two beats abandons the refill; the next one completes
        run_refill(7'h0C, 1'b0, 0, NB - 1, 2, 50, 1'b0);
        run_refill(7'h0C, 1'b0, 0, NB - 1, 0, 50, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_refill(AW'($urandom), 1'b0, 3,
                       ($urandom_range(7, 0) == 0) ? int'($urandom_range(NB - 1, 0)) : NB - 1,
                       ($urandom_range(9, 0) == 0) ? int'($urandom_range(NB, 1)) : 0,
                       50, 1'(($urandom_range(1, 0))));
        end

        repeat (3) begin
            drive_rd(50, 1'b0);
            tick();
        end
        check("write_count", DW'(obs_writes), DW'(exp_writes));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
